// File: rtl/ads1256_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : ads1256_scan_sched
// Purpose  : Round-robin single-ended channel scan scheduler for the ADS1256.
//            On each DRDY_n it reprograms the MUX to the next enabled channel
//            and issues SYNC/WAKEUP/RDATA. After the t6 delay it reads the
//            24-bit result. Each result belongs to the channel programmed
//            one step earlier, and is tagged with that channel.
// Revision : 1.0 - initial release
// ============================================================================
module ads1256_scan_sched #(
   parameter int          NUM_CH    = 8,
   parameter int          T6_CYCLES = 7,
   parameter logic [15:0] DRDY_TO   = 16'hFFFF
) (
   input  logic              clk_fsm,
   input  logic              rst_n,
   input  logic              scan_en,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              drdy_n,
   output logic              spi_start,
   output logic [23:0]       spi_wr_data,
   input  logic              spi_wr_done,
   input  logic              spi_rd_done,
   input  logic [23:0]       spi_rd_data,
   output logic              ad_cs_n,
   output logic              sample_valid,
   output logic [2:0]        sample_ch,
   output logic [23:0]       sample_data,
   output logic              scan_done,
   output logic              timeout_err
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_PICK      = 4'd1;
   localparam logic [3:0] S_WAIT_DRDY = 4'd2;
   localparam logic [3:0] S_TX_MUX    = 4'd3;
   localparam logic [3:0] S_GAP       = 4'd4;
   localparam logic [3:0] S_TX_CMD    = 4'd5;
   localparam logic [3:0] S_WAIT_T6   = 4'd6;
   localparam logic [3:0] S_RD        = 4'd7;
   localparam logic [3:0] S_EMIT      = 4'd8;

   localparam logic [23:0] CMD_WORD = 24'hFC0001;   // SYNC, WAKEUP, RDATA
   localparam logic [15:0] T6_LAST  = 16'(T6_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = DRDY_TO - 16'd1;

   logic [3:0]        state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [2:0]        cur_ch_q, cur_ch_d;
   logic [2:0]        prev_ch_q, prev_ch_d;
   logic              primed_q, primed_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [23:0]       rd_word_q, rd_word_d;
   logic              timeout_q, timeout_d;
   logic              sample_valid_q, sample_valid_d;
   logic [2:0]        sample_ch_q, sample_ch_d;
   logic [23:0]       sample_data_q, sample_data_d;
   logic              scan_done_q, scan_done_d;
   logic              drdy_meta_q, drdy_meta_d;
   logic              drdy_sync_q, drdy_sync_d;

   logic [2:0]        low_ch;    // lowest set bit of the live mask (scan start)
   logic [2:0]        hi_ch;     // highest set bit of the latched mask
   logic [2:0]        nxt_ch;    // next set bit above cur_ch, wrapping
   logic [23:0]       mux_word;

   assign mux_word = {8'h51, 8'h00, 1'b0, cur_ch_q, 4'b1000};

   // Channel search helpers over the live and latched masks
   always_comb begin
      int   idx;
      logic found;
      low_ch = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) low_ch = 3'(i);
      end
      hi_ch = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mask_q[i]) hi_ch = 3'(i);
      end
      nxt_ch = cur_ch_q;
      found  = 1'b0;
      idx    = 0;
      // k = NUM_CH lands back on cur_ch, so a single set bit keeps cur_ch
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = int'(cur_ch_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!found && mask_q[idx]) begin
            nxt_ch = 3'(idx);
            found  = 1'b1;
         end
      end
   end

   // State and datapath registers; reset returns everything to idle values
   always_ff @(posedge clk_fsm) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         mask_q         <= '0;
         cur_ch_q       <= 3'd0;
         prev_ch_q      <= 3'd0;
         primed_q       <= 1'b0;
         cnt_q          <= 16'd0;
         rd_word_q      <= 24'd0;
         timeout_q      <= 1'b0;
         sample_valid_q <= 1'b0;
         sample_ch_q    <= 3'd0;
         sample_data_q  <= 24'd0;
         scan_done_q    <= 1'b0;
         drdy_meta_q    <= 1'b1;
         drdy_sync_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         cur_ch_q       <= cur_ch_d;
         prev_ch_q      <= prev_ch_d;
         primed_q       <= primed_d;
         cnt_q          <= cnt_d;
         rd_word_q      <= rd_word_d;
         timeout_q      <= timeout_d;
         sample_valid_q <= sample_valid_d;
         sample_ch_q    <= sample_ch_d;
         sample_data_q  <= sample_data_d;
         scan_done_q    <= scan_done_d;
         drdy_meta_q    <= drdy_meta_d;
         drdy_sync_q    <= drdy_sync_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      cur_ch_d       = cur_ch_q;
      prev_ch_d      = prev_ch_q;
      primed_d       = primed_q;
      cnt_d          = cnt_q;
      rd_word_d      = rd_word_q;
      timeout_d      = timeout_q;
      sample_valid_d = 1'b0;
      sample_ch_d    = sample_ch_q;
      sample_data_d  = sample_data_q;
      scan_done_d    = 1'b0;
      drdy_meta_d    = drdy_n;
      drdy_sync_d    = drdy_meta_q;
      case (state_q)
         S_IDLE: begin
            if (scan_en && (|ch_mask)) begin
               mask_d   = ch_mask;
               cur_ch_d = low_ch;
               cnt_d    = 16'd0;
               state_d  = S_WAIT_DRDY;
            end
         end
         S_PICK: begin
            cur_ch_d = nxt_ch;
            cnt_d    = 16'd0;
            state_d  = S_WAIT_DRDY;
         end
         S_WAIT_DRDY: begin
            if (!drdy_sync_q) begin
               state_d = S_TX_MUX;
            end else if (cnt_q == TO_LAST) begin
               // Give up on DRDY but keep the scan moving
               timeout_d = 1'b1;
               state_d   = S_TX_MUX;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_TX_MUX: begin
            if (spi_wr_done) state_d = S_GAP;
         end
         S_GAP: begin
            state_d = S_TX_CMD;
         end
         S_TX_CMD: begin
            if (spi_wr_done) begin
               cnt_d   = 16'd0;
               state_d = S_WAIT_T6;
            end
         end
         S_WAIT_T6: begin
            if (cnt_q == T6_LAST) state_d = S_RD;
            else                  cnt_d   = cnt_q + 16'd1;
         end
         S_RD: begin
            if (spi_rd_done) begin
               rd_word_d = spi_rd_data;
               state_d   = S_EMIT;
            end
         end
         S_EMIT: begin
            // The word just read belongs to the channel programmed last time
            if (primed_q) begin
               sample_valid_d = 1'b1;
               sample_ch_d    = prev_ch_q;
               sample_data_d  = rd_word_q;
               scan_done_d    = (prev_ch_q == hi_ch);
            end
            primed_d  = 1'b1;
            prev_ch_d = cur_ch_q;
            state_d   = scan_en ? S_PICK : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Entering IDLE clears the error flag and re-arms the priming discard
      if (state_d == S_IDLE) begin
         timeout_d = 1'b0;
         primed_d  = 1'b0;
      end
   end

   // SPI request, write word and chip select decoded from the current state
   always_comb begin
      spi_start   = 1'b0;
      spi_wr_data = 24'd0;
      ad_cs_n     = 1'b0;
      case (state_q)
         S_IDLE:   ad_cs_n = 1'b1;
         S_TX_MUX: begin
            spi_start   = 1'b1;
            spi_wr_data = mux_word;
         end
         S_TX_CMD: begin
            spi_start   = 1'b1;
            spi_wr_data = CMD_WORD;
         end
         S_RD:     spi_start = 1'b1;
         default:  spi_start = 1'b0;
      endcase
   end

   assign sample_valid = sample_valid_q;
   assign sample_ch    = sample_ch_q;
   assign sample_data  = sample_data_q;
   assign scan_done    = scan_done_q;
   assign timeout_err  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ads1256_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads1256_scan_sched
// Purpose  : Self-checking bench for ads1256_scan_sched with an SPI/ADC
//            responder model and a sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads1256_scan_sched;

   localparam int LAT = 3;   // SPI transaction length in clk_fsm cycles

   logic        clk_fsm = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_en = 1'b0;
   logic [7:0]  ch_mask = 8'h00;
   logic        drdy_n = 1'b1;
   logic        spi_start;
   logic [23:0] spi_wr_data;
   logic        spi_wr_done = 1'b0;
   logic        spi_rd_done = 1'b0;
   logic [23:0] spi_rd_data = 24'd0;
   logic        ad_cs_n;
   logic        sample_valid;
   logic [2:0]  sample_ch;
   logic [23:0] sample_data;
   logic        scan_done;
   logic        timeout_err;

   ads1256_scan_sched #(
      .NUM_CH    (8),
      .T6_CYCLES (7),
      .DRDY_TO   (16'd100)
   ) dut (
      .clk_fsm      (clk_fsm),
      .rst_n        (rst_n),
      .scan_en      (scan_en),
      .ch_mask      (ch_mask),
      .drdy_n       (drdy_n),
      .spi_start    (spi_start),
      .spi_wr_data  (spi_wr_data),
      .spi_wr_done  (spi_wr_done),
      .spi_rd_done  (spi_rd_done),
      .spi_rd_data  (spi_rd_data),
      .ad_cs_n      (ad_cs_n),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .scan_done    (scan_done),
      .timeout_err  (timeout_err)
   );

   always #5 clk_fsm = ~clk_fsm;

   int n_cmp = 0;
   int n_err = 0;
   int n_samp = 0;
   int epoch = 0;
   logic drdy_on = 1'b0;

   // Scoreboard entries: {scan_done, channel, data}
   logic [27:0] sb_q[$];

   // Responder / ADC model state (written only by the responder process)
   int          m_st = 0;
   int          m_lat = 0;
   int          m_phase = 0;
   int          m_cyc = 0;
   int          m_fall = -100;
   int          m_dcnt = 0;
   int          m_mux_n = 0;
   int          m_seen_ep = 0;
   logic [2:0]  m_exp_ch = 3'd0;
   logic [2:0]  m_cur_ch = 3'd0;
   logic [2:0]  m_prev = 3'd0;
   logic        m_primed = 1'b0;
   logic [23:0] m_pend = 24'd0;
   logic [23:0] m_conv = 24'd0;
   logic [23:0] m_out = 24'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] lo_bit(input logic [7:0] m);
      logic [2:0] r = 3'd0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [2:0] hi_bit(input logic [7:0] m);
      logic [2:0] r = 3'd0;
      for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
      return r;
   endfunction

   function automatic logic [2:0] nxt_bit(input logic [7:0] m, input logic [2:0] c);
      for (int k = 1; k <= 8; k++) begin
         int j;
         j = (int'(c) + k) % 8;
         if (m[j]) return 3'(j);
      end
      return c;
   endfunction

   // DRDY generator plus SPI engine and pipelined ADC model
   initial begin : p_resp
      forever begin
         @(negedge clk_fsm);
         m_cyc++;
         spi_wr_done = 1'b0;
         spi_rd_done = 1'b0;
         if (drdy_on) begin
            m_dcnt = (m_dcnt + 1) % 40;
            drdy_n = (m_dcnt >= 10);
            if (m_dcnt == 0) m_fall = m_cyc;
         end else begin
            drdy_n = 1'b1;
         end
         if (!rst_n || epoch != m_seen_ep) begin
            m_seen_ep = epoch;
            m_st      = 0;
            m_phase   = 0;
            m_mux_n   = 0;
            m_primed  = 1'b0;
            m_exp_ch  = lo_bit(ch_mask);
            sb_q.delete();
         end else begin
            case (m_st)
               0: if (spi_start) begin
                  if (m_phase == 0) begin
                     chk("mux_word", {8'h0, spi_wr_data}, {8'h0, 8'h51, 8'h00, 1'b0, m_exp_ch, 4'b1000});
                     if (m_mux_n > 0 && drdy_on) chk("drdy_latency", m_cyc - m_fall, 3);
                     m_mux_n++;
                  end else if (m_phase == 1) begin
                     chk("cmd_word", {8'h0, spi_wr_data}, 32'h00FC0001);
                  end
                  m_lat = LAT;
                  m_st  = 1;
               end
               1: begin
                  m_lat--;
                  if (m_lat == 0) begin
                     if (m_phase == 2) begin
                        spi_rd_data = m_out;
                        spi_rd_done = 1'b1;
                     end else begin
                        spi_wr_done = 1'b1;
                     end
                     m_st = 2;
                  end
               end
               default: begin
                  chk("start_fall", {31'd0, spi_start}, 32'd0);
                  case (m_phase)
                     0: begin
                        m_pend   = 24'h0000C0 + 24'({1'b0, m_exp_ch, 4'b1000});
                        m_cur_ch = m_exp_ch;
                     end
                     1: begin
                        m_out  = m_conv;
                        m_conv = m_pend;
                     end
                     default: begin
                        if (m_primed)
                           sb_q.push_back({(m_prev == hi_bit(ch_mask)), m_prev, m_out});
                        m_primed = 1'b1;
                        m_prev   = m_cur_ch;
                        m_exp_ch = nxt_bit(ch_mask, m_exp_ch);
                     end
                  endcase
                  m_phase = (m_phase + 1) % 3;
                  m_st    = 0;
               end
            endcase
         end
      end
   end

   // Sample monitor: pop expectations as the DUT emits samples
   initial begin : p_mon
      logic [27:0] e;
      forever begin
         @(negedge clk_fsm);
         if (rst_n && sample_valid) begin
            n_samp++;
            if (sb_q.size() == 0) begin
               chk("sample_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("sample_ch", {29'd0, sample_ch}, {29'd0, e[26:24]});
               chk("sample_data", {8'd0, sample_data}, {8'd0, e[23:0]});
               chk("scan_done", {31'd0, scan_done}, {31'd0, e[27]});
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_start"}, {31'd0, spi_start}, 32'd0);
      chk({tag, "_wr_data"}, {8'd0, spi_wr_data}, 32'd0);
      chk({tag, "_cs_n"}, {31'd0, ad_cs_n}, 32'd1);
      chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
      chk({tag, "_ch"}, {29'd0, sample_ch}, 32'd0);
      chk({tag, "_data"}, {8'd0, sample_data}, 32'd0);
      chk({tag, "_done"}, {31'd0, scan_done}, 32'd0);
      chk({tag, "_timeout"}, {31'd0, timeout_err}, 32'd0);
   endtask

   task automatic wait_samples(input int n, input int budget);
      int target = n_samp + n;
      int c = 0;
      while (n_samp < target && c < budget) begin
         @(negedge clk_fsm);
         c++;
      end
      chk("wait_samples", {31'd0, (n_samp >= target)}, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      do begin
         @(negedge clk_fsm);
         c++;
      end while (!ad_cs_n && c < budget);
      chk("wait_idle", {31'd0, ad_cs_n}, 32'd1);
   endtask

   task automatic wait_tx_mux(input int budget, input string tag);
      int c = 0;
      logic seen = 1'b0;
      while (!seen && c < budget) begin
         @(negedge clk_fsm);
         c++;
         seen = spi_start && (spi_wr_data[23:16] == 8'h51);
      end
      chk(tag, {31'd0, seen}, 32'd1);
   endtask

   initial begin : p_main
      int c;
      int bad;
      int s0;
      logic seen;

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk_fsm);
      check_reset("rst0");
      rst_n = 1'b1;
      drdy_on = 1'b1;

      // Mask 0x05: ordering, priming discard, scan_done on ch2
      ch_mask = 8'h05;
      epoch++;
      scan_en = 1'b1;
      wait_samples(4, 3000);
      scan_en = 1'b0;
      wait_idle(500);
      repeat (5) @(negedge clk_fsm);
      chk("sb_empty_05", sb_q.size(), 32'd0);

      // Empty mask: nothing happens
      ch_mask = 8'h00;
      epoch++;
      scan_en = 1'b1;
      bad = 0;
      repeat (1000) begin
         @(negedge clk_fsm);
         if (!ad_cs_n || spi_start) bad++;
      end
      chk("empty_mask_activity", bad, 32'd0);
      scan_en = 1'b0;
      repeat (3) @(negedge clk_fsm);

      // Single channel 7
      ch_mask = 8'h80;
      epoch++;
      scan_en = 1'b1;
      wait_samples(3, 2000);
      scan_en = 1'b0;
      wait_idle(500);
      repeat (5) @(negedge clk_fsm);
      chk("sb_empty_80", sb_q.size(), 32'd0);

      // DRDY timeout
      drdy_on = 1'b0;
      ch_mask = 8'h01;
      epoch++;
      scan_en = 1'b1;
      c = 0;
      do begin
         @(negedge clk_fsm);
         c++;
      end while (ad_cs_n && c < 50);
      chk("to_cs_low", {31'd0, ad_cs_n}, 32'd0);
      c = 0;
      do begin
         @(negedge clk_fsm);
         c++;
      end while (!timeout_err && c < 300);
      chk("to_cycles", c, 32'd100);
      scan_en = 1'b0;
      wait_tx_mux(20, "to_tx_mux");
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);
      wait_idle(500);
      chk("to_cleared", {31'd0, timeout_err}, 32'd0);
      drdy_on = 1'b1;
      repeat (5) @(negedge clk_fsm);

      // Stop during RD: one sample, then idle with no further requests
      ch_mask = 8'h03;
      epoch++;
      scan_en = 1'b1;
      wait_samples(2, 2000);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 200) begin
         @(negedge clk_fsm);
         c++;
         seen = spi_start && (spi_wr_data == 24'd0);
      end
      chk("stop_rd_seen", {31'd0, seen}, 32'd1);
      scan_en = 1'b0;
      s0 = n_samp;
      wait_idle(200);
      repeat (3) @(negedge clk_fsm);
      chk("stop_one_sample", n_samp - s0, 32'd1);
      bad = 0;
      repeat (100) begin
         @(negedge clk_fsm);
         if (spi_start || !ad_cs_n) bad++;
      end
      chk("stop_quiet", bad, 32'd0);
      chk("sb_empty_stop", sb_q.size(), 32'd0);

      // Reset during TX_MUX, then restart re-primes
      ch_mask = 8'h06;
      epoch++;
      scan_en = 1'b1;
      wait_samples(2, 2000);
      wait_tx_mux(200, "rst_tx_mux_seen");
      rst_n = 1'b0;
      @(negedge clk_fsm);
      check_reset("rst_mid");
      rst_n = 1'b1;
      wait_samples(2, 2000);
      scan_en = 1'b0;
      wait_idle(500);
      repeat (5) @(negedge clk_fsm);
      chk("sb_empty_rst", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : p_watchdog
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
